// File: rtl/gigatron_loader_if.sv
// rtl/gigatron_loader_if.sv - byte stream valid/ready handshake between host and loader
interface gigatron_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/gigatron_loader.sv
// rtl/gigatron_loader.sv - framed byte-stream boot loader for Gigatron ROM/RAM with CPU reset control
module gigatron_loader #(
   parameter int ROM_AW = 16,
   parameter int RAM_AW = 16
) (
   input  logic              clock,
   input  logic              rst_n,
   gigatron_loader_if.slave  src,
   output logic [ROM_AW-1:0] rom_addr,
   output logic [15:0]       rom_data,
   output logic              rom_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [7:0]        ram_data,
   output logic              ram_we,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              error
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_AH, ST_AL, ST_LH, ST_LL, ST_DHI, ST_DLO, ST_DAT, ST_CSUM, ST_RUN
   } state_t;

   state_t      state;
   logic [1:0]  rst_sync;
   logic        is_rom;
   logic [15:0] addr_q;
   logic [15:0] count;
   logic [7:0]  sum;
   logic [7:0]  hi_byte;
   logic        accept;
   logic [7:0]  b;

   // Two-stage release so in_ready comes up cleanly after reset deassertion.
   assign src.in_ready = rst_sync[1];
   assign accept       = src.in_valid & rst_sync[1];
   assign b            = src.in_data;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync  <= 2'b00;
         state     <= ST_IDLE;
         is_rom    <= 1'b0;
         addr_q    <= '0;
         count     <= '0;
         sum       <= '0;
         hi_byte   <= '0;
         rom_addr  <= '0;
         rom_data  <= '0;
         rom_we    <= 1'b0;
         ram_addr  <= '0;
         ram_data  <= '0;
         ram_we    <= 1'b0;
         cpu_rst_n <= 1'b0;
         busy      <= 1'b0;
         error     <= 1'b0;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
         rom_we   <= 1'b0;
         ram_we   <= 1'b0;
         if (accept) begin
            sum <= 8'(sum + b);
            case (state)
               ST_IDLE: begin
                  case (b)
                     8'h01, 8'h02: begin
                        state  <= ST_AH;
                        is_rom <= (b == 8'h01);
                        sum    <= b;
                        busy   <= 1'b1;
                     end
                     8'h03: begin
                        if (!error) begin
                           state     <= ST_RUN;
                           cpu_rst_n <= 1'b1;
                        end
                     end
                     8'h04: begin
                        state <= ST_IDLE;
                     end
                     default: error <= 1'b1;
                  endcase
               end
               ST_AH: begin
                  addr_q[15:8] <= b;
                  state        <= ST_AL;
               end
               ST_AL: begin
                  addr_q[7:0] <= b;
                  state       <= ST_LH;
               end
               ST_LH: begin
                  count[15:8] <= b;
                  state       <= ST_LL;
               end
               ST_LL: begin
                  count <= {count[15:8], b};
                  if ({count[15:8], b} == 16'h0000) state <= ST_CSUM;
                  else if (is_rom)                  state <= ST_DHI;
                  else                              state <= ST_DAT;
               end
               ST_DHI: begin
                  hi_byte <= b;
                  state   <= ST_DLO;
               end
               ST_DLO: begin
                  rom_we   <= 1'b1;
                  rom_addr <= addr_q[ROM_AW-1:0];
                  rom_data <= {hi_byte, b};
                  addr_q   <= 16'(addr_q + 16'd1);
                  count    <= 16'(count - 16'd1);
                  state    <= (count == 16'd1) ? ST_CSUM : ST_DHI;
               end
               ST_DAT: begin
                  ram_we   <= 1'b1;
                  ram_addr <= addr_q[RAM_AW-1:0];
                  ram_data <= b;
                  addr_q   <= 16'(addr_q + 16'd1);
                  count    <= 16'(count - 16'd1);
                  state    <= (count == 16'd1) ? ST_CSUM : ST_DAT;
               end
               ST_CSUM: begin
                  // A good record sums to zero including its checksum byte.
                  if (8'(sum + b) != 8'h00) error <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
               ST_RUN: begin
                  if (b == 8'h04) begin
                     state     <= ST_IDLE;
                     cpu_rst_n <= 1'b0;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gigatron_loader.sv
// tb/tb_gigatron_loader.sv - scoreboard bench for gigatron_loader with RAM_AW=16 and RAM_AW=8 instances
module tb_gigatron_loader;
   logic clock = 1'b0;
   logic rst_n = 1'b0;
   always #5 clock = ~clock;

   logic [7:0] din = 8'h00;
   logic       dval = 1'b0;

   gigatron_loader_if s16 ();
   gigatron_loader_if s8 ();
   assign s16.in_data  = din;
   assign s16.in_valid = dval;
   assign s8.in_data   = din;
   assign s8.in_valid  = dval;

   logic [15:0] rom_addr16, rom_data16, ram_addr16, rom_addr8, rom_data8;
   logic [7:0]  ram_data16, ram_data8, ram_addr8;
   logic        rom_we16, ram_we16, cpu16, busy16, err16;
   logic        rom_we8, ram_we8, cpu8, busy8, err8;

   gigatron_loader #(.ROM_AW(16), .RAM_AW(16)) u16 (
      .clock(clock), .rst_n(rst_n), .src(s16.slave),
      .rom_addr(rom_addr16), .rom_data(rom_data16), .rom_we(rom_we16),
      .ram_addr(ram_addr16), .ram_data(ram_data16), .ram_we(ram_we16),
      .cpu_rst_n(cpu16), .busy(busy16), .error(err16));

   gigatron_loader #(.ROM_AW(16), .RAM_AW(8)) u8 (
      .clock(clock), .rst_n(rst_n), .src(s8.slave),
      .rom_addr(rom_addr8), .rom_data(rom_data8), .rom_we(rom_we8),
      .ram_addr(ram_addr8), .ram_data(ram_data8), .ram_we(ram_we8),
      .cpu_rst_n(cpu8), .busy(busy8), .error(err8));

   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
      logic [31:0] t;
   } wr_t;

   wr_t ram_q16[$], ram_q8[$], rom_q16[$], rom_q8[$];
   int  checks = 0;
   int  passes = 0;
   bit  model_err = 0;
   bit  model_run = 0;
   bit  gaps = 0;
   logic [7:0] pl [0:63];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Monitor: every strobe must match the oldest expected write, including its cycle.
   always @(negedge clock) begin
      wr_t e;
      if (ram_we16) begin
         if (ram_q16.size() == 0) chk("ram16_unexpected", 1, 0);
         else begin
            e = ram_q16.pop_front();
            chk("ram16_addr", {16'h0, ram_addr16}, {16'h0, e.a});
            chk("ram16_data", {24'h0, ram_data16}, {16'h0, e.d});
            chk("ram16_time", 32'($time), e.t);
         end
      end
      if (ram_we8) begin
         if (ram_q8.size() == 0) chk("ram8_unexpected", 1, 0);
         else begin
            e = ram_q8.pop_front();
            chk("ram8_addr", {24'h0, ram_addr8}, {16'h0, e.a});
            chk("ram8_data", {24'h0, ram_data8}, {16'h0, e.d});
            chk("ram8_time", 32'($time), e.t);
         end
      end
      if (rom_we16) begin
         if (rom_q16.size() == 0) chk("rom16_unexpected", 1, 0);
         else begin
            e = rom_q16.pop_front();
            chk("rom16_addr", {16'h0, rom_addr16}, {16'h0, e.a});
            chk("rom16_data", {16'h0, rom_data16}, {16'h0, e.d});
            chk("rom16_time", 32'($time), e.t);
         end
      end
      if (rom_we8) begin
         if (rom_q8.size() == 0) chk("rom8_unexpected", 1, 0);
         else begin
            e = rom_q8.pop_front();
            chk("rom8_addr", {16'h0, rom_addr8}, {16'h0, e.a});
            chk("rom8_data", {16'h0, rom_data8}, {16'h0, e.d});
            chk("rom8_time", 32'($time), e.t);
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Driver sits 2 time units after a rising edge between calls.
   task automatic send(input logic [7:0] b, input bit exp_busy);
      if (gaps && $urandom_range(0, 3) == 0) begin
         dval = 1'b0;
         @(posedge clock); #2;
      end
      din  = b;
      dval = 1'b1;
      chk("in_ready", {30'h0, s16.in_ready, s8.in_ready}, 32'h3);
      @(posedge clock); #2;
      dval = 1'b0;
      chk("busy", {30'h0, busy16, busy8}, {30'h0, exp_busy, exp_busy});
   endtask

   task automatic push_ram(input logic [15:0] a, input logic [7:0] d);
      ram_q16.push_back('{a: a, d: {8'h00, d}, t: 32'($time + 3)});
      ram_q8.push_back('{a: a & 16'h00FF, d: {8'h00, d}, t: 32'($time + 3)});
   endtask

   task automatic push_rom(input logic [15:0] a, input logic [15:0] d);
      rom_q16.push_back('{a: a, d: d, t: 32'($time + 3)});
      rom_q8.push_back('{a: a, d: d, t: 32'($time + 3)});
   endtask

   task automatic check_status(input string nm);
      chk({nm, "_error"}, {30'h0, err16, err8}, {30'h0, model_err, model_err});
      chk({nm, "_cpu"}, {30'h0, cpu16, cpu8}, {30'h0, model_run, model_run});
   endtask

   task automatic frame(input logic [7:0] cmd, input logic [15:0] addr, input int len, input bit bad);
      logic [7:0]  sum;
      logic [7:0]  c;
      logic [15:0] ln;
      ln  = 16'(len);
      sum = 8'(cmd + addr[15:8] + addr[7:0] + ln[15:8] + ln[7:0]);
      send(cmd, 1); send(addr[15:8], 1); send(addr[7:0], 1);
      send(ln[15:8], 1); send(ln[7:0], 1);
      for (int i = 0; i < len; i++) begin
         if (cmd == 8'h01) begin
            send(pl[2*i], 1);
            send(pl[2*i+1], 1);
            push_rom(16'(addr + i), {pl[2*i], pl[2*i+1]});
            sum = 8'(sum + pl[2*i] + pl[2*i+1]);
         end else begin
            send(pl[i], 1);
            push_ram(16'(addr + i), pl[i]);
            sum = 8'(sum + pl[i]);
         end
      end
      c = 8'(8'h00 - sum);
      if (bad) c = c ^ 8'h5A;
      send(c, 0);
      if (bad) model_err = 1;
      chk("drained", ram_q16.size() + ram_q8.size() + rom_q16.size() + rom_q8.size(), 0);
      check_status("frame");
   endtask

   task automatic run_cmd();
      send(8'h03, 0);
      if (!model_err) model_run = 1;
      check_status("run");
   endtask

   task automatic halt_cmd();
      send(8'h04, 0);
      model_run = 0;
      check_status("halt");
   endtask

   task automatic other_byte(input logic [7:0] b);
      send(b, 0);
      if (!model_run) model_err = 1;
      check_status("other");
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      dval  = 1'b0;
      #1;
      chk("rst_ready", {30'h0, s16.in_ready, s8.in_ready}, 0);
      chk("rst_we", {28'h0, rom_we16, ram_we16, rom_we8, ram_we8}, 0);
      chk("rst_addr16", {rom_addr16, ram_addr16}, 0);
      chk("rst_data16", {8'h0, rom_data16, ram_data16}, 0);
      chk("rst_ctl", {26'h0, cpu16, busy16, err16, cpu8, busy8, err8}, 0);
      chk("rst_addr8", {8'h0, rom_addr8, ram_addr8}, 0);
      ram_q16.delete(); ram_q8.delete(); rom_q16.delete(); rom_q8.delete();
      model_err = 0;
      model_run = 0;
      @(posedge clock); @(posedge clock); #2;
      rst_n = 1'b1;
      @(posedge clock); #2;
      chk("ready_edge1", {30'h0, s16.in_ready, s8.in_ready}, 0);
      @(posedge clock); #2;
      chk("ready_edge2", {30'h0, s16.in_ready, s8.in_ready}, 32'h3);
   endtask

   initial begin
      logic [7:0] jb;
      #7;
      do_reset();

      pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
      frame(8'h02, 16'h1000, 3, 0);

      pl[0] = 8'h12; pl[1] = 8'h34;
      frame(8'h01, 16'h0000, 1, 0);
      run_cmd();

      send(8'h02, 0); send(8'h55, 0);
      check_status("run_junk");
      halt_cmd();

      pl[0] = 8'h5E; pl[1] = 8'hA1;
      frame(8'h02, 16'hFFFF, 2, 0);

      pl[0] = 8'h11; pl[1] = 8'h22;
      frame(8'h02, 16'h0200, 2, 1);
      run_cmd();
      do_reset();
      frame(8'h01, 16'h0040, 0, 0);
      run_cmd();
      halt_cmd();
      other_byte(8'h7F);
      halt_cmd();

      // Abort mid-payload: the strobe pending from the last byte must vanish.
      do_reset();
      pl[0] = 8'h31; pl[1] = 8'h32;
      send(8'h02, 1); send(8'h30, 1); send(8'h00, 1); send(8'h00, 1); send(8'h04, 1);
      send(pl[0], 1); push_ram(16'h3000, pl[0]);
      send(pl[1], 1);
      do_reset();
      pl[0] = 8'hDE; pl[1] = 8'hAD; pl[2] = 8'hBE; pl[3] = 8'hEF;
      frame(8'h01, 16'h0100, 2, 0);
      run_cmd();
      halt_cmd();

      gaps = 1;
      for (int it = 0; it < 80; it++) begin
         if (model_run) begin
            if ($urandom_range(0, 2) == 0) halt_cmd();
            else begin
               jb = 8'($urandom);
               if (jb == 8'h04) jb = 8'h05;
               other_byte(jb);
            end
         end else begin
            for (int k = 0; k < 64; k++) pl[k] = 8'($urandom);
            case ($urandom_range(0, 9))
               0, 1, 2, 3: frame(8'h02, $urandom_range(0, 1) ? 16'($urandom) : 16'hFFFE,
                                 $urandom_range(0, 4), $urandom_range(0, 5) == 0);
               4, 5: frame(8'h01, $urandom_range(0, 1) ? 16'($urandom) : 16'hFFFF,
                           $urandom_range(0, 4), $urandom_range(0, 5) == 0);
               6: run_cmd();
               7: halt_cmd();
               8: other_byte(8'($urandom_range(5, 255)));
               default: do_reset();
            endcase
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
